alu_arbiter: RTL and testbench

//  Shares one combinational ALU (4-bit op select, 16 functions) between 4 requesters.

---
 rtl/alu_arbiter_if.sv | 29 ++
 rtl/alu_arbiter.sv | 81 ++++++++
 tb/tb_alu_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle between four ALU requesters, the shared ALU and the response consumer.
// A transfer happens on a rising edge where valid and ready are both high; the
// requester keeps valid/op/operands stable until accepted, and the arbiter keeps
// rsp_id_o/rsp_result_o stable while rsp_valid_o is high and rsp_ready_i is low.
interface alu_arbiter_if #(parameter int N = 4);
  logic [3:0]     req_valid_i;
  logic [15:0]    req_op_i;
  logic [4*N-1:0] req_a_i;
  logic [4*N-1:0] req_b_i;
  logic [3:0]     req_ready_o;
  logic [3:0]     alu_sel_o;
  logic [N-1:0]   alu_a_o;
  logic [N-1:0]   alu_b_o;
  logic [N-1:0]   alu_result_i;
  logic           rsp_valid_o;
  logic [1:0]     rsp_id_o;
  logic [N-1:0]   rsp_result_o;
  logic           rsp_ready_i;

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, alu_result_i, rsp_ready_i,
    output req_ready_o, alu_sel_o, alu_a_o, alu_b_o, rsp_valid_o, rsp_id_o, rsp_result_o
  );

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i, alu_result_i, rsp_ready_i,
    input  req_ready_o, alu_sel_o, alu_a_o, alu_b_o, rsp_valid_o, rsp_id_o, rsp_result_o
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between four requesters.
// Each operation walks accept -> execute -> respond; dbg_state exposes the FSM.
module alu_arbiter #(
  parameter int N    = 4,
  parameter int NREQ = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  alu_arbiter_if.slave bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] grant;
  logic [1:0] cand;
  logic       grant_any;

  // Search starts just after the last grant and wraps back to it last.
  always_comb begin
    grant     = 2'd0;
    grant_any = 1'b0;
    cand      = 2'd0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = ptr + 2'(i);
      if (!grant_any && bus.req_valid_i[cand]) begin
        grant     = cand;
        grant_any = 1'b1;
      end
    end
  end

  assign bus.req_ready_o = (state == IDLE && grant_any && !rst_i) ? (4'b0001 << grant) : 4'b0000;
  assign dbg_state       = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= IDLE;
      ptr              <= 2'd3;
      bus.alu_sel_o    <= '0;
      bus.alu_a_o      <= '0;
      bus.alu_b_o      <= '0;
      bus.rsp_valid_o  <= 1'b0;
      bus.rsp_id_o     <= '0;
      bus.rsp_result_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            bus.alu_sel_o <= bus.req_op_i[{grant, 2'b00} +: 4];
            bus.alu_a_o   <= bus.req_a_i[32'(grant) * N +: N];
            bus.alu_b_o   <= bus.req_b_i[32'(grant) * N +: N];
            bus.rsp_id_o  <= grant;
            ptr           <= grant;
            state         <= EXEC;
          end
        end
        EXEC: begin
          bus.rsp_result_o <= bus.alu_result_i;
          bus.rsp_valid_o  <= 1'b1;
          state            <= RESP;
        end
        RESP: begin
          // Response and ALU latches stay frozen until the consumer takes it.
          if (bus.rsp_ready_i) begin
            bus.rsp_valid_o <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: random and directed requests, a transaction-level
// reference model feeding an expected queue, and a negedge monitor that checks.
module tb_alu_arbiter;
  localparam int N = 8;
  localparam int W = N + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  alu_arbiter_if #(.N(N)) bus ();

  alu_arbiter #(.N(N), .NREQ(4)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- external ALU ----------------
  function automatic logic [N-1:0] alu_fn(input logic [3:0] op, input logic [N-1:0] a,
                                          input logic [N-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~(a & b);
      4'd6:    return ~(a | b);
      4'd7:    return ~(a ^ b);
      4'd8:    return a << 1;
      4'd9:    return a >> 1;
      4'd10:   return a;
      4'd11:   return b;
      4'd12:   return ~a;
      4'd13:   return a + 1'b1;
      4'd14:   return a - 1'b1;
      default: return (a < b) ? N'(1) : N'(0);
    endcase
  endfunction

  assign bus.alu_result_i = alu_fn(bus.alu_sel_o, bus.alu_a_o, bus.alu_b_o);

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + monitor ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] rsp_log[$];
  int           grant_q[$];
  int           mod_ptr  = 3;
  bit           busy     = 1'b0;
  int           age      = 0;
  bit           prev_rst = 1'b1;
  logic [3:0]   cur_op;
  logic [N-1:0] cur_a;
  logic [N-1:0] cur_b;

  always @(negedge clk) begin
    int         g;
    logic [3:0] exp_ready;
    logic [W-1:0] exp_rsp;
    for (int k = 0; k < 4; k++)
      if (bus.req_ready_o[k]) grant_q.push_back(k);
    if (prev_rst) begin
      check("rst_alu_sel", 32'(bus.alu_sel_o), 32'd0);
      check("rst_alu_a", 32'(bus.alu_a_o), 32'd0);
      check("rst_alu_b", 32'(bus.alu_b_o), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
      check("rst_rsp_id", 32'(bus.rsp_id_o), 32'd0);
      check("rst_rsp_result", 32'(bus.rsp_result_o), 32'd0);
    end
    if (rst) begin
      check("rst_req_ready", 32'(bus.req_ready_o), 32'd0);
      exp_q.delete();
      busy    = 1'b0;
      mod_ptr = 3;
    end else begin
      g = -1;
      if (!busy)
        for (int i = 1; i <= 4; i++)
          if (g < 0 && bus.req_valid_i[(mod_ptr + i) % 4]) g = (mod_ptr + i) % 4;
      exp_ready = (g >= 0) ? 4'(1 << g) : 4'd0;
      check("req_ready", 32'(bus.req_ready_o), 32'(exp_ready));
      if (busy) begin
        age++;
        if (age == 1) begin
          check("alu_sel", 32'(bus.alu_sel_o), 32'(cur_op));
          check("alu_a", 32'(bus.alu_a_o), 32'(cur_a));
          check("alu_b", 32'(bus.alu_b_o), 32'(cur_b));
        end
        check("rsp_valid", 32'(bus.rsp_valid_o), (age >= 2) ? 32'd1 : 32'd0);
        if (bus.rsp_valid_o && bus.rsp_ready_i) begin
          rsp_log.push_back({bus.rsp_id_o, bus.rsp_result_o});
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 32'd1, 32'd0);
          end else begin
            exp_rsp = exp_q.pop_front();
            check("rsp_id", 32'(bus.rsp_id_o), 32'(exp_rsp[W-1 -: 2]));
            check("rsp_result", 32'(bus.rsp_result_o), 32'(exp_rsp[N-1:0]));
          end
          busy = 1'b0;
        end
      end else if (g >= 0) begin
        cur_op  = bus.req_op_i[4*g +: 4];
        cur_a   = bus.req_a_i[N*g +: N];
        cur_b   = bus.req_b_i[N*g +: N];
        exp_q.push_back({2'(g), alu_fn(cur_op, cur_a, cur_b)});
        busy    = 1'b1;
        age     = 0;
        mod_ptr = g;
      end else begin
        check("idle_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
      end
    end
    prev_rst = rst;
  end

  // ---------------- driver ----------------
  bit           pend[4];
  logic [3:0]   op_r[4];
  logic [N-1:0] a_r[4];
  logic [N-1:0] b_r[4];

  task automatic drive();
    for (int k = 0; k < 4; k++) begin
      bus.req_valid_i[k]       = pend[k];
      bus.req_op_i[4*k +: 4]   = op_r[k];
      bus.req_a_i[N*k +: N]    = a_r[k];
      bus.req_b_i[N*k +: N]    = b_r[k];
    end
  endtask

  task automatic set_req(input int k, input logic [3:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b);
    pend[k] = 1'b1;
    op_r[k] = op;
    a_r[k]  = a;
    b_r[k]  = b;
    drive();
  endtask

  task automatic step();
    logic [3:0] acc;
    @(negedge clk);
    acc = bus.req_ready_o;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++)
      if (acc[k]) pend[k] = 1'b0;
    drive();
  endtask

  function automatic bit any_pend();
    return pend[0] | pend[1] | pend[2] | pend[3];
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((any_pend() || busy || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_taken(input int k, input int budget);
    int n = 0;
    while (pend[k] && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check("wait_taken_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int k = 0; k < 4; k++) begin
      pend[k] = 1'b0;
      op_r[k] = '0;
      a_r[k]  = '0;
      b_r[k]  = '0;
    end
    bus.req_valid_i = '0;
    bus.req_op_i    = '0;
    bus.req_a_i     = '0;
    bus.req_b_i     = '0;
    bus.rsp_ready_i = 1'b1;
    drive();
    step();
    step();
    rst = 1'b0;

    // Single add from requester 0
    rsp_log.delete();
    set_req(0, 4'd0, 8'd3, 8'd4);
    wait_idle(20);
    check("t1_rsp_count", 32'(rsp_log.size()), 32'd1);
    if (rsp_log.size() > 0) check("t1_rsp", 32'(rsp_log[0]), 32'({2'd0, 8'd7}));

    // All four valid: rotation 0,1,2,3,0
    do_reset();
    grant_q.delete();
    for (int k = 0; k < 4; k++) set_req(k, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
    wait_taken(0, 20);
    set_req(0, 4'd4, 8'h5A, 8'hFF);
    wait_idle(60);
    check("t2_grant_count", 32'(grant_q.size()), 32'd5);
    if (grant_q.size() == 5) begin
      check("t2_grant0", 32'(grant_q[0]), 32'd0);
      check("t2_grant1", 32'(grant_q[1]), 32'd1);
      check("t2_grant2", 32'(grant_q[2]), 32'd2);
      check("t2_grant3", 32'(grant_q[3]), 32'd3);
      check("t2_grant4", 32'(grant_q[4]), 32'd0);
    end

    // Response stall with another requester waiting
    rsp_log.delete();
    set_req(2, 4'd1, 8'd5, 8'd2);
    bus.rsp_ready_i = 1'b0;
    step();
    step();
    set_req(0, 4'd3, 8'h0F, 8'h30);
    for (int i = 0; i < 6; i++) step();
    bus.rsp_ready_i = 1'b1;
    wait_idle(30);
    check("t3_rsp_count", 32'(rsp_log.size()), 32'd2);
    if (rsp_log.size() > 0) check("t3_rsp", 32'(rsp_log[0]), 32'({2'd2, 8'd3}));

    // Pointer skips idle requesters
    grant_q.delete();
    set_req(1, 4'd0, 8'd1, 8'd2);
    wait_idle(20);
    set_req(1, 4'd1, 8'd9, 8'd4);
    set_req(3, 4'd2, 8'hAA, 8'h0F);
    wait_idle(30);
    check("t4_grant_count", 32'(grant_q.size()), 32'd3);
    if (grant_q.size() == 3) begin
      check("t4_grant0", 32'(grant_q[0]), 32'd1);
      check("t4_grant1", 32'(grant_q[1]), 32'd3);
      check("t4_grant2", 32'(grant_q[2]), 32'd1);
    end

    // Reset while executing discards the in-flight op
    grant_q.delete();
    rsp_log.delete();
    set_req(0, 4'd0, 8'd1, 8'd1);
    wait_taken(0, 20);
    rst = 1'b1;
    set_req(3, 4'd0, 8'd20, 8'd22);
    set_req(0, 4'd4, 8'd9, 8'd3);
    step();
    rst = 1'b0;
    wait_idle(30);
    check("t5_rsp_count", 32'(rsp_log.size()), 32'd2);
    if (rsp_log.size() == 2) begin
      check("t5_rsp0", 32'(rsp_log[0]), 32'({2'd0, 8'd10}));
      check("t5_rsp1", 32'(rsp_log[1]), 32'({2'd3, 8'd42}));
    end
    if (grant_q.size() >= 2) check("t5_grant_after_rst", 32'(grant_q[1]), 32'd0);

    // 8-bit AND
    rsp_log.delete();
    set_req(3, 4'd2, 8'hF0, 8'h3C);
    wait_idle(20);
    if (rsp_log.size() > 0) check("t6_and", 32'(rsp_log[0]), 32'({2'd3, 8'h30}));
    else check("t6_rsp_count", 32'(rsp_log.size()), 32'd1);

    // Random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++)
        if (!pend[k] && $urandom_range(0, 2) == 0)
          set_req(k, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
      step();
    end
    bus.rsp_ready_i = 1'b1;
    wait_idle(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
